// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings driven on mul_div_unit.op by the decoder
//   - FSM state type for the unit
//   - helpers classifying an op as a multi-cycle multiply- or divide-class op
// Optional build macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU become multiply-class ops).
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for MUL_CYCLES.
  function automatic logic mdu_is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

  // Ops that occupy the unit for DIV_CYCLES.
  function automatic logic mdu_is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// mdu_compute: purely combinational 64-bit result of a multiply/divide op.
// Ports:
//   op     - op code (mdu_pkg encodings)
//   a, b   - rs / rt operands
//   hilo   - current {hi, lo}, used as accumulator and as the "unchanged" value
//   result - new {hi, lo}; equals hilo for ops that do not produce a result
//   keep   - divide by zero: hi/lo must be left unchanged at commit
// Optional build macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU accumulate results).
module mdu_compute import mdu_pkg::*; (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] result,
  output logic        keep
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;

  // Signed divide is done on magnitudes so that 0x80000000 / -1 needs no special
  // case: |0x80000000| / 1 = 0x80000000, and negating that wraps back to itself.
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_s;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] div_u;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign b_zero = (b == 32'd0);

  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b[31] ? (~b + 32'd1) : b;

  // Substitute a divisor of 1 on zero so the divider never sees 0; the result is
  // discarded through keep in that case.
  assign div_s = b_zero ? 32'd1 : b_mag;
  assign q_mag = a_mag / div_s;
  assign r_mag = a_mag % div_s;
  // Quotient truncates toward zero; remainder takes the sign of the dividend.
  assign q_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;

  assign div_u = b_zero ? 32'd1 : b;
  assign q_u   = a / div_u;
  assign r_u   = a % div_u;

  always_comb begin
    result = hilo;
    keep   = 1'b0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV: begin
        keep = b_zero;
        if (!b_zero) begin
          result = {r_s, q_s};
        end
      end
      MDU_DIVU: begin
        keep = b_zero;
        if (!b_zero) begin
          result = {r_u, q_u};
        end
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  result = hilo + prod_s;
      MDU_MADDU: result = hilo + prod_u;
      MDU_MSUB:  result = hilo - prod_s;
      MDU_MSUBU: result = hilo - prod_u;
`else
      // Accumulate ops not built: behave as undefined ops.
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: result = hilo;
`endif
      default: result = hilo;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit for the EX stage; owns HI/LO.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset; aborts any in-flight op without commit
//   start - issue op this cycle (ignored while busy)
//   op    - op code (mdu_pkg encodings)
//   a, b  - rs / rt operands after forwarding
//   busy  - op in flight; high for exactly N cycles after the accepting edge
//   hi,lo - architectural HI / LO
// Parameters: MUL_CYCLES, DIV_CYCLES (>= 1) set the busy duration per op class.
// Optional build macro: MDU_MADD_EN (accepts MADD/MADDU/MSUB/MSUBU with MUL_CYCLES).
module mul_div_unit import mdu_pkg::*; #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state;
  logic [31:0] cnt;
  logic [63:0] shadow;
  logic        shadow_keep;

  logic [63:0] res;
  logic        res_keep;
  logic        accept_mul;
  logic        accept_div;

  mdu_compute u_compute (
    .op     (op),
    .a      (a),
    .b      (b),
    .hilo   ({hi, lo}),
    .result (res),
    .keep   (res_keep)
  );

  assign accept_mul = mdu_is_mul_op(op);
  assign accept_div = mdu_is_div_op(op);

  // The result is captured at the accepting edge. hi/lo cannot change during RUN,
  // so the accumulate ops see the same {hi, lo} as they would at commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      busy        <= 1'b0;
      cnt         <= 32'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      shadow      <= 64'd0;
      shadow_keep <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            if (accept_mul || accept_div) begin
              shadow      <= res;
              shadow_keep <= res_keep;
              cnt         <= accept_div ? DIV_CYCLES : MUL_CYCLES;
              busy        <= 1'b1;
              state       <= StRun;
            end else if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end
          end
        end
        StRun: begin
          // cnt == 1 marks the edge N cycles after acceptance.
          if (cnt == 32'd1) begin
            if (!shadow_keep) begin
              {hi, lo} <= shadow;
            end
            cnt   <= 32'd0;
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          cnt   <= 32'd0;
        end
      endcase
    end
  end

endmodule
